// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-128 encryptor:
//   - aes_state_e : FSM state encoding (IDLE / ROUND / DONE)
//   - LAST_ROUND  : index of the final round (no MixColumns)
//   - rcon()      : round-constant table, indexed by round number 1..10
//   - xtime()     : multiply by x in GF(2^8), reduction polynomial 0x11B
//   - gf_mul()    : general GF(2^8) multiply built from xtime/XOR
//   - mix_column(): one MixColumns column (circulant 02 03 01 01)
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-XOR multiply: accumulate a*x^i for every set bit i of b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ p;
      end else begin
        acc = acc;
      end
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
    b1 = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
    b2 = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
    b3 = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_encrypt_iter_if.sv
// ---------------------------------------------------------------------------
// aes_encrypt_iter_if
// Request/response bundle of the AES-128 encryptor.
//   master : requester (drives in_valid/plaintext/key[/out_ready])
//   slave  : encryptor (drives in_ready/out_valid/ciphertext/busy)
// Build option AES_OUT_HOLD_EN adds out_ready so the result is held until
// the consumer takes it.
// ---------------------------------------------------------------------------
interface aes_encrypt_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic [127:0] ciphertext;
  logic         busy;
`ifdef AES_OUT_HOLD_EN
  logic         out_ready;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );
  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
`else
  modport master (
    output in_valid, plaintext, key,
    input  in_ready, out_valid, ciphertext, busy
  );
  modport slave (
    input  in_valid, plaintext, key,
    output in_ready, out_valid, ciphertext, busy
  );
`endif
endinterface

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Forward AES S-box, purely combinational.
//   in_i  [7:0] : input byte
//   out_o [7:0] : substituted byte
// Table is packed MSB-first: entry 0 sits in bits [2047:2040].
// ---------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SBOX_TABLE[11'd2047 - {in_i, 3'b000} -: 8];

endmodule

// File: rtl/aes_encrypt_iter.sv
// ---------------------------------------------------------------------------
// aes_encrypt_iter
// Iterative AES-128 encryptor: one round per clock, key schedule computed on
// the fly, 10 cycles from acceptance to result.
// Ports:
//   clk    : sole clock, rising edge
//   rst    : asynchronous active-high reset (aborts any block in flight)
//   aes_if : aes_encrypt_iter_if.slave
//            in_valid/in_ready/plaintext/key  - request
//            out_valid/ciphertext             - result
//            busy                             - high while rounds run
//            out_ready                        - only with AES_OUT_HOLD_EN
// Build option AES_OUT_HOLD_EN: hold DONE/out_valid until out_ready; without
// it out_valid is a single-cycle pulse.
// Byte order: [127:120] = byte0 (row0,col0), column-major.
// ---------------------------------------------------------------------------
module aes_encrypt_iter
  import aes_pkg::*;
(
  input logic               clk,
  input logic               rst,
  aes_encrypt_iter_if.slave aes_if
);

  aes_state_e   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] ct_q, ct_d;
  logic [3:0]   round_q, round_d;

  logic         last_round_s;
  logic         done_exit_s;
  logic         in_ready_s;
  logic         busy_s;
  logic         out_valid_s;

  logic [7:0]   sb_s [16];
  logic [7:0]   ksb_s [4];
  logic [127:0] shifted_s;
  logic [127:0] mixed_s;
  logic [127:0] round_out_s;
  logic [127:0] state_next_s;
  logic [31:0]  key_temp_s;
  logic [31:0]  kw0_s, kw1_s, kw2_s, kw3_s;
  logic [127:0] rk_next_s;

  assign last_round_s = (round_q == LAST_ROUND);

`ifdef AES_OUT_HOLD_EN
  assign done_exit_s = aes_if.out_ready;
`else
  assign done_exit_s = 1'b1;
`endif

  // SubBytes on every state byte.
  for (genvar gi = 0; gi < 16; gi++) begin : g_state_sbox
    aes_sbox u_sbox (
      .in_i  (state_q[127-8*gi -: 8]),
      .out_o (sb_s[gi])
    );
  end

  // SubWord(RotWord(w3)): w3 is bytes 12..15, rotated to 13,14,15,12.
  for (genvar gk = 0; gk < 4; gk++) begin : g_key_sbox
    aes_sbox u_sbox (
      .in_i  (rk_q[127-8*(12+((gk+1)%4)) -: 8]),
      .out_o (ksb_s[gk])
    );
  end

  // ShiftRows: row r of column c takes the byte from column (c+r) mod 4.
  for (genvar gc = 0; gc < 4; gc++) begin : g_col
    for (genvar gr = 0; gr < 4; gr++) begin : g_row
      assign shifted_s[127-8*(4*gc+gr) -: 8] = sb_s[4*((gc+gr)%4)+gr];
    end
    assign mixed_s[127-32*gc -: 32] = mix_column(shifted_s[127-32*gc -: 32]);
  end

  assign round_out_s  = last_round_s ? shifted_s : mixed_s;
  assign state_next_s = round_out_s ^ rk_next_s;

  // Key expansion step: derive the round key used by the current round.
  always_comb begin
    key_temp_s = {ksb_s[0], ksb_s[1], ksb_s[2], ksb_s[3]} ^ {rcon(round_q), 24'h000000};
    kw0_s      = rk_q[127:96] ^ key_temp_s;
    kw1_s      = rk_q[95:64]  ^ kw0_s;
    kw2_s      = rk_q[63:32]  ^ kw1_s;
    kw3_s      = rk_q[31:0]   ^ kw2_s;
    rk_next_s  = {kw0_s, kw1_s, kw2_s, kw3_s};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: begin
        if (aes_if.in_valid) begin
          fsm_d = ST_ROUND;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_ROUND: begin
        if (last_round_s) begin
          fsm_d = ST_DONE;
        end else begin
          fsm_d = ST_ROUND;
        end
      end
      ST_DONE: begin
        if (done_exit_s) begin
          fsm_d = ST_IDLE;
        end else begin
          fsm_d = ST_DONE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // FSM output decode, straight from the state register.
  always_comb begin
    in_ready_s  = 1'b0;
    busy_s      = 1'b0;
    out_valid_s = 1'b0;
    case (fsm_q)
      ST_IDLE:  in_ready_s  = 1'b1;
      ST_ROUND: busy_s      = 1'b1;
      ST_DONE:  out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        busy_s      = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Datapath next-state: load on acceptance, one round per ROUND cycle.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    ct_d    = ct_q;
    case (fsm_q)
      ST_IDLE: begin
        if (aes_if.in_valid) begin
          state_d = aes_if.plaintext ^ aes_if.key;
          rk_d    = aes_if.key;
          round_d = 4'd1;
        end else begin
          round_d = round_q;
        end
      end
      ST_ROUND: begin
        state_d = state_next_s;
        rk_d    = rk_next_s;
        if (last_round_s) begin
          ct_d    = state_next_s;
          round_d = 4'd0;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: begin
        round_d = round_q;
      end
    endcase
  end

  // Datapath registers; ciphertext only changes at completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 128'd0;
      rk_q    <= 128'd0;
      ct_q    <= 128'd0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      ct_q    <= ct_d;
      round_q <= round_d;
    end
  end

  assign aes_if.in_ready   = in_ready_s;
  assign aes_if.busy       = busy_s;
  assign aes_if.out_valid  = out_valid_s;
  assign aes_if.ciphertext = ct_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_encrypt_iter
// Directed bench for aes_encrypt_iter. A byte-level AES reference (S-box built
// from the GF(2^8) inverse and affine map, full key expansion) plus a
// transaction timeline predicts every output; a compare process checks the
// DUT each falling edge. Known-answer vectors pin the reference itself.
// Honors AES_OUT_HOLD_EN for the held-output variant.
// ---------------------------------------------------------------------------
module tb_aes_encrypt_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  aes_encrypt_iter_if bus();

  aes_encrypt_iter dut (
    .clk    (clk),
    .rst    (rst),
    .aes_if (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference AES ----------------
  logic [7:0] sbox_t [256];

  // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
        tmp = w[4*rnd+c];
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ tmp[31-8*r -: 8];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- transaction timeline ----------------
  int           m_rem = 0;     // rounds still to run
  bit           m_out = 1'b0;  // result being presented
  logic [127:0] m_ct = '0;
  logic [127:0] m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  <= 0;
      m_out  <= 1'b0;
      m_ct   <= '0;
      m_pend <= '0;
    end else if (m_out) begin
`ifdef AES_OUT_HOLD_EN
      if (bus.out_ready) m_out <= 1'b0;
`else
      m_out <= 1'b0;
`endif
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_out <= 1'b1;
        m_ct  <= m_pend;
      end
    end else if (bus.in_valid) begin
      m_rem  <= 10;
      m_pend <= aes_model(bus.plaintext, bus.key);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",   {127'd0, bus.in_ready},  {127'd0, (m_rem == 0) && !m_out});
      chk("busy",       {127'd0, bus.busy},      {127'd0, m_rem > 0});
      chk("out_valid",  {127'd0, bus.out_valid}, {127'd0, m_out});
      chk("ciphertext", bus.ciphertext,          m_ct);
    end
  end

  // ---------------- stimulus ----------------
  // Called away from the rising edge; returns at the falling edge after acceptance.
  task automatic send(input logic [127:0] pt, input logic [127:0] k, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    bus.plaintext = pt;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        acc = cyc;
        ok  = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_out(output int done);
    bit got;
    got  = 1'b0;
    done = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        got  = 1'b1;
        done = cyc;
        break;
      end
    end
    if (!got) chk("out_valid_timeout", 128'd0, 128'd1);
  endtask

  task automatic run(input string name, input logic [127:0] pt, input logic [127:0] k,
                     input logic [127:0] want, output int acc, output int done);
    send(pt, k, acc);
    wait_out(done);
    chk(name, bus.ciphertext, want);
    chk({name, "_latency"}, 128'(done - acc), 128'd10);
  endtask

  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    int acc, done, acc2, done2;
    bus.in_valid  = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
`ifdef AES_OUT_HOLD_EN
    bus.out_ready = 1'b1;
`endif
    build_sbox();
    chk("model_fips",  aes_model(P_B, K_B), C_B);
    chk("model_c1",    aes_model(P_C, K_C), C_C);
    chk("model_zero",  aes_model('0, '0),   C_Z);

    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_in_ready",  {127'd0, bus.in_ready},  128'd1);
    chk("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("rst_busy",      {127'd0, bus.busy},      128'd0);
    chk("rst_ct",        bus.ciphertext,          128'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Known-answer vectors, issued back to back.
    run("ct_fips", P_B, K_B, C_B, acc, done);
    run("ct_c1",   P_C, K_C, C_C, acc2, done2);
    chk("back_to_back_gap", 128'(acc2 - done), 128'd2);
    run("ct_zero", '0, '0, C_Z, acc, done);

    // New request offered mid-operation must be ignored.
    @(negedge clk);
    send(P_B, K_B, acc);
    repeat (2) @(negedge clk);
    bus.plaintext = P_C;
    bus.key       = K_C;
    bus.in_valid  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("ignore_in_ready", {127'd0, bus.in_ready}, 128'd0);
    end
    bus.in_valid = 1'b0;
    wait_out(done);
    chk("ignore_result", bus.ciphertext, C_B);
    chk("ignore_latency", 128'(done - acc), 128'd10);

    // Reset while round 5 is running aborts the block.
    @(negedge clk);
    @(negedge clk);
    send(P_C, K_C, acc);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_in_ready",  {127'd0, bus.in_ready},  128'd1);
    chk("abort_busy",      {127'd0, bus.busy},      128'd0);
    chk("abort_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("abort_ct",        bus.ciphertext,          128'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_ct_after", bus.ciphertext, 128'd0);
    run("ct_after_abort", P_B, K_B, C_B, acc, done);

`ifdef AES_OUT_HOLD_EN
    // Consumer stalls for 7 cycles; result must stay presented.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(P_C, K_C, acc);
    wait_out(done);
    chk("hold_latency", 128'(done - acc), 128'd10);
    repeat (7) begin
      @(negedge clk);
      chk("hold_out_valid", {127'd0, bus.out_valid}, 128'd1);
      chk("hold_ct",        bus.ciphertext,          C_C);
      chk("hold_in_ready",  {127'd0, bus.in_ready},  128'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_idle", {127'd0, bus.in_ready},  128'd1);
    chk("hold_release_ov",   {127'd0, bus.out_valid}, 128'd0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit %0d cycles", 20000);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_encrypt_iter.md
AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have in_valid, input, 1, plaintext/key presented.
REQ-004 SHALL have in_ready, output, 1, block can accept a new request.
REQ-005 SHALL have plaintext, input, 128, FIPS-197 state: [127:120]=byte0 (row0,col0), [119:112]=byte1 (row1,col0), column-major.
REQ-006 SHALL have key, input, 128, AES-128 cipher key with the same byte order.
REQ-007 SHALL have out_valid, output, 1, ciphertext valid.
REQ-008 SHALL have ciphertext, output, 128, result with the same byte order.
REQ-009 SHALL have busy, output, 1, high in ROUND state.
REQ-010 SHALL have out_ready, input, 1, consumer accepts result (present only with AES_OUT_HOLD_EN).

Function
REQ-011 SHALL implement FSM IDLE -> ROUND -> DONE -> IDLE; in_ready=1 only in IDLE.
REQ-012 SHALL accept on in_valid&&in_ready at edge N: state<=plaintext^key, rk<=key, round<=1, go to ROUND; inputs are not sampled after edge N.
REQ-013 SHALL, at edges N+1..N+10, perform one round per cycle: SubBytes, forward ShiftRows (row r rotated left r bytes), MixColumns (matrix 02 03 01 01 circulant), XOR with the next round key.
REQ-014 SHALL omit MixColumns in round 10.
REQ-015 SHALL derive the next round key on the fly from rk: RotWord, SubWord, XOR Rcon[round] (01,02,04,08,10,20,40,80,1B,36) into word0, then chain XOR words 1..3.
REQ-016 SHALL do all byte arithmetic in GF(2^8): addition=XOR, multiply via xtime with 0x1B reduction; no integer add/multiply.
REQ-017 SHALL, at edge N+10, load ciphertext register, go to DONE, and assert out_valid; latency is 10 cycles from acceptance edge.
REQ-018 SHALL hold ciphertext stable from completion until the next completion.
REQ-019 SHALL ignore in_valid while not in IDLE; no request queuing.
REQ-020 SHALL allow back-to-back operation: the next request can be accepted in the cycle after DONE exits.

Reset
REQ-021 SHALL, on rst, asynchronously force IDLE, round=0, in_ready=1, out_valid=0, busy=0, ciphertext=0, and internal state/rk=0.
REQ-022 SHALL treat rst mid-operation as an abort: the result is discarded and out_valid is never asserted for the aborted block.

Configuration
REQ-023 SHALL use macro AES_OUT_HOLD_EN.
REQ-024 SHALL, with AES_OUT_HOLD_EN defined, provide out_ready, hold DONE/out_valid until out_valid&&out_ready, then go to IDLE.
REQ-025 SHALL, without AES_OUT_HOLD_EN, omit out_ready, assert out_valid for exactly one cycle, then go to IDLE.

Structure
REQ-026 SHALL place the Rcon table, FSM state encoding, and xtime/GF-multiply functions in shared package aes_pkg.
REQ-027 SHALL instantiate the forward S-box as sub-module aes_sbox (8-bit in, 8-bit out, combinational): 16 instances for state, 4 for key schedule.

Verification
REQ-028 SHALL cover key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after acceptance.
REQ-029 SHALL cover key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-030 SHALL cover all-zero key and plaintext -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
REQ-031 SHALL cover in_valid with new data during ROUND -> request ignored, in_ready=0, first result unchanged.
REQ-032 SHALL cover rst at round 5 -> all outputs 0, no out_valid, then a fresh request gives the correct result.
REQ-033 SHALL cover, with AES_OUT_HOLD_EN, out_ready low for 7 cycles -> out_valid and ciphertext held, in_ready=0, IDLE one cycle after handshake.
